poly_nco: RTL



---
 rtl/poly_nco.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/poly_nco.sv
// rtl/poly_nco.sv - polyphonic NCO: key-to-voice allocator, per-voice phase accumulators, waveform mixer
// Work per sample is spread over NUM_KEYS allocation cycles, then NUM_VOICES accumulate cycles.
module poly_nco #(
  parameter int NUM_KEYS   = 12,
  parameter int NUM_VOICES = 4,
  parameter int ACC_W      = 32,
  parameter int SAMPLE_W   = 16
) (
  input  logic                            master_clk,
  input  logic                            rst,
  input  logic                            sample_clk_en,
  input  logic [NUM_KEYS-1:0]             key_pressed,
  input  logic [NUM_KEYS*ACC_W-1:0]       key_increment,
  input  logic [1:0]                      wave_sel,
  output logic signed [SAMPLE_W-1:0]      sample_output,
  output logic                            sample_valid,
  output logic [$clog2(NUM_VOICES):0]     voices_active,
  output logic                            voice_overflow,
  output logic                            sample_overrun
);

  localparam int LOG_V = $clog2(NUM_VOICES);
  localparam int KW    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int MIX_W = SAMPLE_W + LOG_V;
  localparam int CW    = LOG_V + 1;

  typedef enum logic [1:0] {IDLE, ALLOC, ACCUM, OUT} state_t;

  state_t                      state, state_nxt;
  logic [NUM_KEYS-1:0]         keys_q;
  logic [1:0]                  wave_q;
  logic [KW-1:0]               key_cnt;
  logic [LOG_V-1:0]            voice_cnt;
  logic [NUM_VOICES-1:0]       busy;
  logic [KW-1:0]               key_idx [NUM_VOICES];
  logic [ACC_W-1:0]            phase   [NUM_VOICES];
  logic                        ovf_pend;
  logic signed [MIX_W-1:0]     mix;

  logic                        last_key, last_voice;
  logic                        hold_hit, free_hit;
  logic [LOG_V-1:0]            hold_v, free_v;
  logic [ACC_W-1:0]            incr, phase_sum;
  logic [SAMPLE_W-1:0]         u, wave, half;
  logic [SAMPLE_W-2:0]         tri_f;
  logic signed [MIX_W-1:0]     mix_sum, mix_shift;
  logic [CW-1:0]               active_cnt;

  assign last_key   = (key_cnt == KW'(NUM_KEYS - 1));
  assign last_voice = (voice_cnt == LOG_V'(NUM_VOICES - 1));

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (sample_clk_en) state_nxt = ALLOC;
      ALLOC: if (last_key)      state_nxt = ACCUM;
      ACCUM: if (last_voice)    state_nxt = OUT;
      OUT:                      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Descending scan so the lowest-index match wins.
  always_comb begin
    hold_hit = 1'b0;
    hold_v   = '0;
    free_hit = 1'b0;
    free_v   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (busy[v] && key_idx[v] == key_cnt) begin
        hold_hit = 1'b1;
        hold_v   = LOG_V'(v);
      end
      if (!busy[v]) begin
        free_hit = 1'b1;
        free_v   = LOG_V'(v);
      end
    end
  end

  always_comb begin
    active_cnt = '0;
    for (int v = 0; v < NUM_VOICES; v++) active_cnt = active_cnt + CW'(busy[v]);
  end

  always_comb begin
    incr      = key_increment[int'(key_idx[voice_cnt]) * ACC_W +: ACC_W];
    phase_sum = phase[voice_cnt] + incr;
    u         = phase_sum[ACC_W-1 -: SAMPLE_W];
    half      = {1'b1, {(SAMPLE_W-1){1'b0}}};
    tri_f     = u[SAMPLE_W-2:0] ^ {(SAMPLE_W-1){u[SAMPLE_W-1]}};
    wave      = '0;
    if (busy[voice_cnt]) begin
      case (wave_q)
        2'd0:    wave = u - half;
        2'd1:    wave = u[SAMPLE_W-1] ? (half + 1'b1) : (half - 1'b1);
        2'd2:    wave = {tri_f, 1'b0} - half;
        default: wave = '0;
      endcase
    end
    mix_sum   = mix + $signed({{LOG_V{wave[SAMPLE_W-1]}}, wave});
    mix_shift = mix_sum >>> LOG_V;
  end

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      keys_q         <= '0;
      wave_q         <= '0;
      key_cnt        <= '0;
      voice_cnt      <= '0;
      busy           <= '0;
      ovf_pend       <= 1'b0;
      mix            <= '0;
      sample_output  <= '0;
      sample_valid   <= 1'b0;
      voices_active  <= '0;
      voice_overflow <= 1'b0;
      sample_overrun <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_idx[v] <= '0;
        phase[v]   <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      if (sample_clk_en && state != IDLE) sample_overrun <= 1'b1;
      case (state)
        IDLE: if (sample_clk_en) begin
          keys_q    <= key_pressed;
          wave_q    <= wave_sel;
          ovf_pend  <= 1'b0;
          mix       <= '0;
          key_cnt   <= '0;
          voice_cnt <= '0;
        end
        ALLOC: begin
          if (hold_hit && !keys_q[key_cnt]) begin
            busy[hold_v] <= 1'b0;
          end else if (!hold_hit && keys_q[key_cnt]) begin
            if (free_hit) begin
              busy[free_v]    <= 1'b1;
              key_idx[free_v] <= key_cnt;
              phase[free_v]   <= '0;
            end else begin
              ovf_pend <= 1'b1;
            end
          end
          key_cnt <= key_cnt + 1'b1;
        end
        ACCUM: begin
          if (busy[voice_cnt]) phase[voice_cnt] <= phase_sum;
          mix       <= mix_sum;
          voice_cnt <= voice_cnt + 1'b1;
          // Outputs load here so they are visible during the OUT cycle.
          if (last_voice) begin
            sample_output  <= mix_shift[SAMPLE_W-1:0];
            sample_valid   <= 1'b1;
            voices_active  <= active_cnt;
            voice_overflow <= ovf_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
